// File: rtl/antilog2_pkg.sv
// Shared widths, stage side-band type and the 2^(k/64) mantissa ROM for antilog2.
// ANTILOG2_INTERP_EN adds the 2-bit fraction used for linear interpolation.
package antilog2_pkg;

   localparam int LOG_W     = 12;
   localparam int OUT_W     = 24;
   localparam int MANT_W    = 16;
   localparam int ADDR_W    = 6;
   localparam int LUT_DEPTH = 1 << ADDR_W;

   // Upper neighbour of the last entry: 32768 * 2^(64/64), never stored.
   localparam logic [MANT_W:0] LUT_TOP = 17'd65536;

   // lut[k] = round(32768 * 2^(k/64))
   localparam logic [MANT_W-1:0] LUT_ROM [LUT_DEPTH] = '{
      16'd32768, 16'd33125, 16'd33486, 16'd33850, 16'd34219, 16'd34591, 16'd34968, 16'd35349,
      16'd35734, 16'd36123, 16'd36516, 16'd36914, 16'd37316, 16'd37722, 16'd38133, 16'd38548,
      16'd38968, 16'd39392, 16'd39821, 16'd40255, 16'd40693, 16'd41136, 16'd41584, 16'd42037,
      16'd42495, 16'd42958, 16'd43425, 16'd43898, 16'd44376, 16'd44859, 16'd45348, 16'd45842,
      16'd46341, 16'd46846, 16'd47356, 16'd47871, 16'd48393, 16'd48920, 16'd49452, 16'd49991,
      16'd50535, 16'd51085, 16'd51642, 16'd52204, 16'd52773, 16'd53347, 16'd53928, 16'd54515,
      16'd55109, 16'd55709, 16'd56316, 16'd56929, 16'd57549, 16'd58176, 16'd58809, 16'd59449,
      16'd60097, 16'd60751, 16'd61413, 16'd62081, 16'd62757, 16'd63441, 16'd64132, 16'd64830
   };

   typedef struct packed {
      logic [3:0] e;
`ifdef ANTILOG2_INTERP_EN
      logic [1:0] f;
`endif
   } side_t;

endpackage

// File: rtl/antilog2_lut.sv
// Registered mantissa ROM with one or two read ports (second port only with ANTILOG2_INTERP_EN).
// The high address is 7 bits so that index 64 returns the implicit 65536 entry.
module antilog2_lut
   import antilog2_pkg::*;
(
   input  logic              clk,
   input  logic              i_en,
   input  logic [ADDR_W-1:0] i_addr_lo,
   output logic [MANT_W-1:0] o_data_lo
`ifdef ANTILOG2_INTERP_EN
   ,
   input  logic [ADDR_W:0]   i_addr_hi,
   output logic [MANT_W:0]   o_data_hi
`endif
);

   logic [MANT_W-1:0] r_lo;

   always_ff @(posedge clk) begin
      if (i_en) begin
         r_lo <= LUT_ROM[i_addr_lo];
      end
   end

   assign o_data_lo = r_lo;

`ifdef ANTILOG2_INTERP_EN
   logic [MANT_W:0] r_hi;

   always_ff @(posedge clk) begin
      if (i_en) begin
         r_hi <= i_addr_hi[ADDR_W] ? LUT_TOP : {1'b0, LUT_ROM[i_addr_hi[ADDR_W-1:0]]};
      end
   end

   assign o_data_hi = r_hi;
`endif

endmodule

// File: rtl/antilog2.sv
// Four-stage stall-able exp2 pipe: DOUT = 256 * 2^(DIN/256), truncated.
// ANTILOG2_INTERP_EN enables interpolation on DIN[1:0]; otherwise DIN[1:0] is ignored.
module antilog2
   import antilog2_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [LOG_W-1:0] DIN,
   input  logic             DIN_VALID,
   output logic             DIN_READY,
   output logic [OUT_W-1:0] DOUT,
   output logic             DOUT_VALID,
   input  logic             DOUT_READY
);

   logic              w_stall;
   logic              w_adv;
   logic [3:0]        r_vld;
   logic [ADDR_W-1:0] r_s1_k;
   side_t             r_s1_side;
   side_t             r_s2_side;
   logic [MANT_W-1:0] w_lut_lo;
   logic [MANT_W-1:0] w_mant;
   logic [MANT_W-1:0] r_s3_mant;
   logic [3:0]        r_s3_e;
   logic [30:0]       w_shift;
   logic [OUT_W-1:0]  w_dout_next;
   logic [OUT_W-1:0]  r_dout;

   // The only hold condition is a result waiting at the output.
   assign w_stall    = r_vld[3] & ~DOUT_READY;
   assign w_adv      = ~w_stall;
   assign DIN_READY  = w_adv;
   assign DOUT_VALID = r_vld[3];
   assign DOUT       = r_dout;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld  <= '0;
         r_dout <= '0;
      end else if (w_adv) begin
         r_vld  <= {r_vld[2:0], DIN_VALID};
         r_dout <= w_dout_next;
      end
   end

   always_ff @(posedge clk) begin
      if (w_adv) begin
         r_s1_k      <= DIN[7:2];
         r_s1_side.e <= DIN[11:8];
`ifdef ANTILOG2_INTERP_EN
         r_s1_side.f <= DIN[1:0];
`endif
         r_s2_side   <= r_s1_side;
         r_s3_mant   <= w_mant;
         r_s3_e      <= r_s2_side.e;
      end
   end

`ifdef ANTILOG2_INTERP_EN
   logic [MANT_W:0] w_lut_hi;
   logic [ADDR_W:0] w_addr_hi;
   logic [9:0]      w_diff;
   logic [11:0]     w_prod;

   assign w_addr_hi = {1'b0, r_s1_k} + 7'd1;

   antilog2_lut u_lut (
      .clk       (clk),
      .i_en      (w_adv),
      .i_addr_lo (r_s1_k),
      .o_data_lo (w_lut_lo),
      .i_addr_hi (w_addr_hi),
      .o_data_hi (w_lut_hi)
   );

   // Neighbour step is at most 706, so the fraction product stays in 12 bits.
   assign w_diff = 10'(w_lut_hi - {1'b0, w_lut_lo});
   assign w_prod = 12'(w_diff) * 12'(r_s2_side.f);
   assign w_mant = w_lut_lo + 16'(w_prod >> 2);
`else
   logic w_unused_f;

   assign w_unused_f = ^DIN[1:0];

   antilog2_lut u_lut (
      .clk       (clk),
      .i_en      (w_adv),
      .i_addr_lo (r_s1_k),
      .o_data_lo (w_lut_lo)
   );

   assign w_mant = w_lut_lo;
`endif

   assign w_shift     = {15'b0, r_s3_mant} << r_s3_e;
   assign w_dout_next = OUT_W'(w_shift >> 7);

endmodule
